cell_pos_mem_dbuf: RTL and testbench



---
 rtl/cell_pos_mem_dbuf.sv | 129 ++++++++++++
 tb/tb_cell_pos_mem_dbuf.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_pos_mem_dbuf.sv
// Ping-pong position memory for one cell. The reader sees the active bank while the writer appends to the shadow bank.
// A single-cycle swap publishes the shadow bank together with its particle count.
module cell_pos_mem_dbuf #(
    parameter int unsigned DATA_WIDTH = 96,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH-1:0] particle_num,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  wr_overflow,
    input  logic                  swap,
    output logic                  active_bank
);

    localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem0 [DEPTH];
    logic [DATA_WIDTH-1:0] mem1 [DEPTH];

    logic                  bank_sel_q,   bank_sel_d;
    logic [ADDR_WIDTH-1:0] active_cnt_q, active_cnt_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q,     wr_ptr_d;
    logic                  overflow_q,   overflow_d;
    logic                  s1_valid_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q;
    logic [ADDR_WIDTH-1:0] s1_cnt_q;
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  rd_valid_q,   rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q,    rd_data_d;

    logic                  full_c;
    logic                  accept_c;
    logic [RAM_AW-1:0]     wr_idx_c;
    logic [RAM_AW-1:0]     rd_idx_c;

    assign full_c   = (wr_ptr_q == LAST_PTR);
    assign accept_c = wr_en && !full_c;
    assign wr_idx_c = RAM_AW'(wr_ptr_q + ADDR_WIDTH'(1));
    assign rd_idx_c = RAM_AW'(rd_addr);

    // Next-state for control counters and the output stage of the read pipe
    always_comb begin
        bank_sel_d   = bank_sel_q;
        active_cnt_d = active_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        overflow_d   = overflow_q;
        rd_valid_d   = s1_valid_q;
        rd_data_d    = '0;

        if (accept_c) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (wr_en && full_c) begin
            overflow_d = 1'b1;
        end
        // Published count includes an append accepted in the swap cycle
        if (swap) begin
            bank_sel_d   = ~bank_sel_q;
            active_cnt_d = wr_ptr_d;
            wr_ptr_d     = '0;
        end

        if (s1_valid_q) begin
            if (s1_addr_q == '0) begin
                rd_data_d = DATA_WIDTH'(s1_cnt_q);
            end else if (s1_addr_q <= s1_cnt_q) begin
                rd_data_d = ram_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_sel_q   <= 1'b0;
            active_cnt_q <= '0;
            wr_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= '0;
            s1_cnt_q     <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            bank_sel_q   <= bank_sel_d;
            active_cnt_q <= active_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            overflow_q   <= overflow_d;
            s1_valid_q   <= rd_en;
            // Bank and count are captured at issue so in-flight reads survive a swap
            if (rd_en) begin
                s1_addr_q <= rd_addr;
                s1_cnt_q  <= active_cnt_q;
            end
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Storage is not reset; a zero count masks stale contents
    always_ff @(posedge clk) begin
        if (accept_c && !rst) begin
            if (bank_sel_q) begin
                mem0[wr_idx_c] <= wr_data;
            end else begin
                mem1[wr_idx_c] <= wr_data;
            end
        end
        if (rd_en) begin
            ram_q <= bank_sel_q ? mem1[rd_idx_c] : mem0[rd_idx_c];
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign particle_num = active_cnt_q;
    assign wr_full      = full_c;
    assign wr_overflow  = overflow_q;
    assign active_bank  = bank_sel_q;

endmodule

// File: tb/tb_cell_pos_mem_dbuf.sv
// Self-checking bench for cell_pos_mem_dbuf: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a bank/queue reference model.
module tb_cell_pos_mem_dbuf;

    localparam int unsigned DW    = 96;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW-1:0] particle_num;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          wr_full;
    logic          wr_overflow;
    logic          swap;
    logic          active_bank;

    always #5 clk = ~clk;

    cell_pos_mem_dbuf #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .particle_num(particle_num),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_full     (wr_full),
        .wr_overflow (wr_overflow),
        .swap        (swap),
        .active_bank (active_bank)
    );

    // Reference model: two plain arrays, a published count, a fill count, and a queue of pending read results
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_exp_t;

    logic [DW-1:0] m_bank [2][DEPTH];
    int            m_sel;
    int            m_cnt;
    int            m_wptr;
    bit            m_ovf;
    rd_exp_t       exp_q[$];
    int            cyc;
    bit            chk_on;
    int            n_cmp;
    int            n_bad;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic step(input bit r, input bit re, input int ra, input bit we,
                        input logic [DW-1:0] wd, input bit sw);
        rd_exp_t e;
        rst     = r;
        rd_en   = re;
        rd_addr = AW'(ra);
        wr_en   = we;
        wr_data = wd;
        swap    = sw;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_sel  = 0;
            m_cnt  = 0;
            m_wptr = 0;
            m_ovf  = 0;
            exp_q.delete();
        end else begin
            if (re) begin
                e.due = cyc + 1;
                if (ra == 0)          e.data = DW'(m_cnt);
                else if (ra <= m_cnt) e.data = m_bank[m_sel][ra];
                else                  e.data = '0;
                exp_q.push_back(e);
            end
            if (we) begin
                if (m_wptr < DEPTH - 1) begin
                    m_wptr++;
                    m_bank[1 - m_sel][m_wptr] = wd;
                end else begin
                    m_ovf = 1;
                end
            end
            if (sw) begin
                m_cnt  = m_wptr;
                m_wptr = 0;
                m_sel  = 1 - m_sel;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, '0, 0);
    endtask

    task automatic rd(input int a);
        step(0, 1, a, 0, '0, 0);
    endtask

    task automatic app(input logic [DW-1:0] d);
        step(0, 0, 0, 1, d, 0);
    endtask

    // Compare the DUT against the model on every cycle
    always @(negedge clk) begin
        if (chk_on) begin
            bit exp_v;
            exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check("rd_valid", DW'(rd_valid), DW'(exp_v));
            if (exp_v) begin
                check("rd_data", rd_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end
            check("particle_num", DW'(particle_num), DW'(m_cnt));
            check("active_bank", DW'(active_bank), DW'(m_sel));
            check("wr_full", DW'(wr_full), DW'(m_wptr == DEPTH - 1));
            check("wr_overflow", DW'(wr_overflow), DW'(m_ovf));
        end
    end

    initial begin
        logic [DW-1:0] a, b, c, d, e, x;
        logic [DW-1:0] w [9];
        n_cmp  = 0;
        n_bad  = 0;
        cyc    = 0;
        chk_on = 0;
        step(1, 0, 0, 0, '0, 0);
        step(1, 0, 0, 0, '0, 0);
        chk_on = 1;

        // Reads after reset return zero
        check("rst_pnum", DW'(particle_num), DW'(0));
        rd(0);
        rd(5);
        check("rst_rd0_valid", DW'(rd_valid), DW'(1));
        check("rst_rd0", rd_data, '0);
        idle();
        check("rst_rd5_valid", DW'(rd_valid), DW'(1));
        check("rst_rd5", rd_data, '0);

        // Three appends, swap, back-to-back readback
        a = rnd96(); b = rnd96(); c = rnd96();
        app(a); app(b); app(c);
        step(0, 0, 0, 0, '0, 1);
        rd(0);
        rd(1);
        check("abc_cnt", rd_data, DW'(3));
        rd(2);
        check("abc_a", rd_data, a);
        rd(3);
        check("abc_b", rd_data, b);
        rd(4);
        check("abc_c", rd_data, c);
        idle();
        check("abc_oob", rd_data, '0);
        check("abc_oob_valid", DW'(rd_valid), DW'(1));
        check("abc_bank", DW'(active_bank), DW'(1));
        check("abc_pnum", DW'(particle_num), DW'(3));

        // Read issued in the swap cycle uses the old bank
        d = rnd96(); e = rnd96();
        step(0, 1, 2, 1, d, 0);
        app(e);
        step(0, 1, 1, 0, '0, 1);
        check("swap_pnum", DW'(particle_num), DW'(2));
        rd(1);
        check("swap_old", rd_data, a);
        idle();
        check("swap_new", rd_data, d);

        // Append and swap together
        for (int i = 0; i < 4; i++) app(rnd96());
        w[0] = rnd96();
        step(0, 0, 0, 1, w[0], 1);
        check("ws_pnum", DW'(particle_num), DW'(5));
        rd(5);
        x = rnd96();
        app(x);
        check("ws_word", rd_data, w[0]);
        step(0, 0, 0, 0, '0, 1);
        rd(1);
        idle();
        check("ws_next_addr1", rd_data, x);

        // Fill past capacity
        step(0, 0, 0, 0, '0, 1);
        for (int i = 0; i < 9; i++) begin
            w[i] = rnd96();
            app(w[i]);
            if (i == 5) check("full_before", DW'(wr_full), DW'(0));
            if (i == 6) check("full_at7", DW'(wr_full), DW'(1));
            if (i == 6) check("ovf_before", DW'(wr_overflow), DW'(0));
        end
        check("ovf_set", DW'(wr_overflow), DW'(1));
        step(0, 0, 0, 0, '0, 1);
        check("full_pnum", DW'(particle_num), DW'(7));
        rd(7);
        rd(9);
        check("full_last", rd_data, w[6]);
        idle();
        check("beyond_depth", rd_data, '0);

        // Reset mid-fill with a read in flight
        app(rnd96()); app(rnd96()); app(rnd96());
        rd(1);
        step(1, 0, 0, 0, '0, 0);
        check("rst_inflight_valid", DW'(rd_valid), DW'(0));
        check("rst_bank", DW'(active_bank), DW'(0));
        check("rst_ovf", DW'(wr_overflow), DW'(0));
        step(0, 0, 0, 0, '0, 1);
        check("rst_wptr_cleared", DW'(particle_num), DW'(0));
        rd(1);
        idle();
        check("rst_rd1", rd_data, '0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                 rnd96(), $urandom_range(0, 9) == 0);
        end
        idle(); idle(); idle();
        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
